// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one single-outstanding memory port between an instruction-fetch
// requester and a load/store requester. Data normally wins contention, but
// a streak counter forces a fetch grant after MAX_DATA_STREAK consecutive
// data grants made while a fetch was waiting. A PC override (fetch_cancel)
// marks the outstanding fetch response to be consumed silently.

module mem_bus_arbiter #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [31:0] fetch_addr,
  input  logic        fetch_addr_en,
  input  logic        fetch_cancel,
  output logic [31:0] fetch_inst,
  output logic        fetch_inst_valid,

  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic        ls_en,
  input  logic        ls_we,
  output logic [31:0] ls_rdata,
  output logic        ls_done,

  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_en,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] FETCH_WAIT = 2'd1;
  localparam logic [1:0] DATA_WAIT  = 2'd2;

  localparam logic [3:0]  STREAK_LIMIT   = 4'(MAX_DATA_STREAK);
  localparam logic [3:0]  STREAK_SAT     = 4'hf;
  localparam logic [31:0] FETCH_IDLE_WORD = 32'hc0defec4;

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic [3:0]  streak_cnt;
  logic        drop;

  // Request parameters captured at grant time; they keep driving the memory
  // port for the whole wait so the memory sees stable address/data.
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_we;

  logic        in_idle;
  logic        fetch_req;
  logic        data_req;
  logic        streak_full;
  logic        grant_fetch;
  logic        grant_data;
  logic        grant_any;
  logic        rsp_fetch;
  logic        rsp_data;

  // Arbitration: a cancelled fetch is not a request this cycle; data wins
  // contention until the streak counter reaches its limit.
  always_comb begin
    in_idle     = (state == IDLE) && !reset;
    fetch_req   = fetch_addr_en && !fetch_cancel;
    data_req    = ls_en;
    streak_full = (streak_cnt == STREAK_LIMIT);
    grant_data  = in_idle && data_req && (!fetch_req || !streak_full);
    grant_fetch = in_idle && fetch_req && !grant_data;
    grant_any   = grant_data || grant_fetch;
  end

  // Memory port: the winner's request goes out combinationally in the grant
  // cycle, otherwise the latched copy of the outstanding request is shown.
  always_comb begin
    mem_en    = grant_any;
    mem_addr  = lat_addr;
    mem_we    = lat_we;
    mem_wdata = lat_wdata;
    if (grant_data) begin
      mem_addr  = ls_addr;
      mem_we    = ls_we;
      mem_wdata = ls_wdata;
    end else if (grant_fetch) begin
      mem_addr  = fetch_addr;
      mem_we    = 1'b0;
      mem_wdata = 32'd0;
    end
  end

  // Response routing: a response only counts in a WAIT state, and a fetch
  // response is swallowed if it was cancelled earlier or in this very cycle.
  always_comb begin
    rsp_fetch        = (state == FETCH_WAIT) && mem_rvalid && !reset;
    rsp_data         = (state == DATA_WAIT) && mem_rvalid && !reset;
    fetch_inst_valid = rsp_fetch && !drop && !fetch_cancel;
    fetch_inst       = fetch_inst_valid ? mem_rdata : FETCH_IDLE_WORD;
    ls_done          = rsp_data;
    ls_rdata         = (rsp_data && !lat_we) ? mem_rdata : 32'd0;
  end

  // Next-state selection for the three-state access sequencer.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_data) begin
          next_state = DATA_WAIT;
        end else if (grant_fetch) begin
          next_state = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (mem_rvalid) begin
          next_state = IDLE;
        end
      end
      DATA_WAIT: begin
        if (mem_rvalid) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register; reset abandons any outstanding access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture the granted request so the port stays stable during the wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_we    <= 1'b0;
    end else if (grant_any) begin
      lat_addr  <= mem_addr;
      lat_wdata <= mem_wdata;
      lat_we    <= mem_we;
    end
  end

  // Count data grants taken while a fetch waits; any fetch grant clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak_cnt <= 4'd0;
    end else if (grant_fetch) begin
      streak_cnt <= 4'd0;
    end else if (grant_data && fetch_addr_en && (streak_cnt != STREAK_SAT)) begin
      streak_cnt <= streak_cnt + 4'd1;
    end
  end

  // Remember a cancel seen during a fetch wait until its response drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop <= 1'b0;
    end else if (state == FETCH_WAIT) begin
      if (mem_rvalid) begin
        drop <= 1'b0;
      end else if (fetch_cancel) begin
        drop <= 1'b1;
      end
    end else begin
      drop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Scenario tasks drive the arbiter cycle by cycle; expected grants and
// responses are queued as stimulus is applied and popped as the DUT emits them.

module tb_mem_bus_arbiter;

  localparam logic [31:0] IDLE_WORD = 32'hc0defec4;

  typedef struct packed {
    logic        fetch;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } grant_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_addr;
  logic        fetch_addr_en;
  logic        fetch_cancel;
  logic [31:0] fetch_inst;
  logic        fetch_inst_valid;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_en;
  logic        ls_we;
  logic [31:0] ls_rdata;
  logic        ls_done;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  int checks = 0;
  int passed = 0;

  grant_t      grant_q[$];
  logic [31:0] rsp_q[$];

  mem_bus_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_addr       (fetch_addr),
    .fetch_addr_en    (fetch_addr_en),
    .fetch_cancel     (fetch_cancel),
    .fetch_inst       (fetch_inst),
    .fetch_inst_valid (fetch_inst_valid),
    .ls_addr          (ls_addr),
    .ls_wdata         (ls_wdata),
    .ls_en            (ls_en),
    .ls_we            (ls_we),
    .ls_rdata         (ls_rdata),
    .ls_done          (ls_done),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_en           (mem_en),
    .mem_we           (mem_we),
    .mem_rdata        (mem_rdata),
    .mem_rvalid       (mem_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to 1 time unit after the next rising edge; inputs are then set
  // and outputs sampled one further unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fetch_addr    = 32'd0;
    fetch_addr_en = 1'b0;
    fetch_cancel  = 1'b0;
    ls_addr       = 32'd0;
    ls_wdata      = 32'd0;
    ls_en         = 1'b0;
    ls_we         = 1'b0;
    mem_rdata     = 32'd0;
    mem_rvalid    = 1'b0;
  endtask

  task automatic do_reset();
    cyc();
    clear_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    cyc();
    fetch_addr_en = 1'b1;
    fetch_addr    = 32'h40;
    ls_en         = 1'b1;
    mem_rvalid    = 1'b1;
    #1;
    checks++; if (mem_en !== 1'b0) $display("[TB] FAIL reset_mem_en: got %b expected 0", mem_en); else passed++;
    checks++; if (fetch_inst_valid !== 1'b0) $display("[TB] FAIL reset_fvalid: got %b expected 0", fetch_inst_valid); else passed++;
    checks++; if (ls_done !== 1'b0) $display("[TB] FAIL reset_ls_done: got %b expected 0", ls_done); else passed++;
    cyc();
    clear_inputs();
    reset = 1'b0;
    #1;
    checks++; if (fetch_inst !== IDLE_WORD) $display("[TB] FAIL reset_finst: got %h expected %h", fetch_inst, IDLE_WORD); else passed++;
    checks++; if (ls_rdata !== 32'd0) $display("[TB] FAIL reset_ls_rdata: got %h expected 0", ls_rdata); else passed++;
    checks++; if (mem_en !== 1'b0) $display("[TB] FAIL reset_idle_mem_en: got %b expected 0", mem_en); else passed++;
  endtask

  task automatic test_fetch_only();
    grant_t g;
    int n;
    cyc();
    fetch_addr    = 32'h100;
    fetch_addr_en = 1'b1;
    grant_q.push_back('{fetch: 1'b1, addr: 32'h100, we: 1'b0, wdata: 32'd0});
    rsp_q.push_back(32'h00500093);
    #1;
    n = 0;
    while (mem_en !== 1'b1 && n < 4) begin
      cyc();
      #1;
      n++;
    end
    checks++; if (mem_en !== 1'b1) $display("[TB] FAIL fetch_grant_timeout: got mem_en %b expected 1", mem_en); else passed++;
    g = grant_q.pop_front();
    checks++; if (mem_addr !== g.addr) $display("[TB] FAIL fetch_addr: got %h expected %h", mem_addr, g.addr); else passed++;
    checks++; if (mem_we !== g.we) $display("[TB] FAIL fetch_we: got %b expected %b", mem_we, g.we); else passed++;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      mem_rvalid = (k == 3);
      mem_rdata  = (k == 3) ? 32'h00500093 : 32'hbad0bad0;
      #1;
      checks++; if (mem_en !== 1'b0) $display("[TB] FAIL fetch_single_pulse: got mem_en %b expected 0 at wait %0d", mem_en, k); else passed++;
      if (k < 3) begin
        checks++; if (fetch_inst_valid !== 1'b0) $display("[TB] FAIL fetch_early_valid: got %b expected 0 at wait %0d", fetch_inst_valid, k); else passed++;
      end else begin
        checks++; if (fetch_inst_valid !== 1'b1) $display("[TB] FAIL fetch_valid: got %b expected 1", fetch_inst_valid); else passed++;
        checks++; if (fetch_inst !== rsp_q[0]) $display("[TB] FAIL fetch_inst: got %h expected %h", fetch_inst, rsp_q[0]); else passed++;
        void'(rsp_q.pop_front());
      end
    end
    cyc();
    clear_inputs();
    #1;
    checks++; if (fetch_inst_valid !== 1'b0) $display("[TB] FAIL fetch_valid_pulse: got %b expected 0", fetch_inst_valid); else passed++;
  endtask

  task automatic test_contention();
    grant_t g;
    logic [31:0] rd;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) == 4) grant_q.push_back('{fetch: 1'b1, addr: 32'h1000, we: 1'b0, wdata: 32'd0});
      else              grant_q.push_back('{fetch: 1'b0, addr: 32'h2000, we: 1'b0, wdata: 32'd0});
    end
    fetch_addr    = 32'h1000;
    fetch_addr_en = 1'b1;
    ls_addr       = 32'h2000;
    ls_en         = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      g = grant_q.pop_front();
      checks++; if (mem_en !== 1'b1) $display("[TB] FAIL contend_grant_%0d: got mem_en %b expected 1", i, mem_en); else passed++;
      checks++; if (mem_addr !== g.addr) $display("[TB] FAIL contend_order_%0d: got addr %h expected %h", i, mem_addr, g.addr); else passed++;
      cyc();
      rd = 32'ha000 + 32'(i);
      rsp_q.push_back(rd);
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
      #1;
      rd = rsp_q.pop_front();
      if (g.fetch) begin
        checks++; if (fetch_inst_valid !== 1'b1 || fetch_inst !== rd) $display("[TB] FAIL contend_fetch_rsp_%0d: got %b/%h expected 1/%h", i, fetch_inst_valid, fetch_inst, rd); else passed++;
      end else begin
        checks++; if (ls_done !== 1'b1 || ls_rdata !== rd) $display("[TB] FAIL contend_data_rsp_%0d: got %b/%h expected 1/%h", i, ls_done, ls_rdata, rd); else passed++;
      end
      cyc();
      mem_rvalid = 1'b0;
      if (i == 9) clear_inputs();
      #1;
    end
    checks++; if (mem_en !== 1'b0) $display("[TB] FAIL contend_quiet: got mem_en %b expected 0", mem_en); else passed++;
  endtask

  task automatic test_cancel();
    cyc();
    fetch_addr    = 32'h200;
    fetch_addr_en = 1'b1;
    fetch_cancel  = 1'b1;
    #1;
    checks++; if (mem_en !== 1'b0) $display("[TB] FAIL cancel_idle_no_grant: got mem_en %b expected 0", mem_en); else passed++;
    cyc();
    fetch_cancel = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h200) $display("[TB] FAIL cancel_grant: got %b/%h expected 1/00000200", mem_en, mem_addr); else passed++;
    cyc();
    fetch_cancel = 1'b1;
    #1;
    cyc();
    fetch_cancel = 1'b0;
    mem_rvalid   = 1'b1;
    mem_rdata    = 32'h11111111;
    #1;
    checks++; if (fetch_inst_valid !== 1'b0) $display("[TB] FAIL cancel_dropped: got %b expected 0", fetch_inst_valid); else passed++;
    checks++; if (fetch_inst !== IDLE_WORD) $display("[TB] FAIL cancel_inst_idle: got %h expected %h", fetch_inst, IDLE_WORD); else passed++;
    cyc();
    mem_rvalid = 1'b0;
    fetch_addr = 32'h204;
    #1;
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h204) $display("[TB] FAIL cancel_next_fetch: got %b/%h expected 1/00000204", mem_en, mem_addr); else passed++;
    cyc();
    mem_rvalid   = 1'b1;
    mem_rdata    = 32'h22222222;
    fetch_cancel = 1'b1;
    #1;
    checks++; if (fetch_inst_valid !== 1'b0) $display("[TB] FAIL cancel_same_cycle: got %b expected 0", fetch_inst_valid); else passed++;
    cyc();
    mem_rvalid   = 1'b0;
    fetch_cancel = 1'b0;
    fetch_addr   = 32'h300;
    #1;
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h300) $display("[TB] FAIL cancel_regrant: got %b/%h expected 1/00000300", mem_en, mem_addr); else passed++;
    cyc();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h33333333;
    #1;
    checks++; if (fetch_inst_valid !== 1'b1 || fetch_inst !== 32'h33333333) $display("[TB] FAIL cancel_flag_cleared: got %b/%h expected 1/33333333", fetch_inst_valid, fetch_inst); else passed++;
    cyc();
    clear_inputs();
  endtask

  task automatic test_store();
    grant_t g;
    cyc();
    ls_en    = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 32'h80;
    ls_wdata = 32'hdeadbeef;
    grant_q.push_back('{fetch: 1'b0, addr: 32'h80, we: 1'b1, wdata: 32'hdeadbeef});
    #1;
    g = grant_q.pop_front();
    checks++; if (mem_en !== 1'b1) $display("[TB] FAIL store_mem_en: got %b expected 1", mem_en); else passed++;
    checks++; if (mem_we !== g.we || mem_wdata !== g.wdata || mem_addr !== g.addr) $display("[TB] FAIL store_port: got %b/%h/%h expected %b/%h/%h", mem_we, mem_wdata, mem_addr, g.we, g.wdata, g.addr); else passed++;
    cyc();
    ls_wdata = 32'h0;
    #1;
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 32'hdeadbeef) $display("[TB] FAIL store_hold: got %b/%b/%h expected 0/1/deadbeef", mem_en, mem_we, mem_wdata); else passed++;
    cyc();
    mem_rvalid = 1'b1;
    #1;
    checks++; if (ls_done !== 1'b1) $display("[TB] FAIL store_done: got %b expected 1", ls_done); else passed++;
    checks++; if (fetch_inst_valid !== 1'b0) $display("[TB] FAIL store_no_fvalid: got %b expected 0", fetch_inst_valid); else passed++;
    cyc();
    mem_rvalid = 1'b0;
    ls_we      = 1'b0;
    ls_addr    = 32'h84;
    #1;
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h84) $display("[TB] FAIL load_b2b_grant: got %b/%b/%h expected 1/0/00000084", mem_en, mem_we, mem_addr); else passed++;
    cyc();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    #1;
    checks++; if (ls_done !== 1'b1 || ls_rdata !== 32'h12345678) $display("[TB] FAIL load_data: got %b/%h expected 1/12345678", ls_done, ls_rdata); else passed++;
    cyc();
    clear_inputs();
    #1;
    checks++; if (ls_done !== 1'b0 || ls_rdata !== 32'd0) $display("[TB] FAIL load_done_pulse: got %b/%h expected 0/00000000", ls_done, ls_rdata); else passed++;
  endtask

  task automatic test_reset_mid_access();
    cyc();
    ls_en         = 1'b1;
    ls_addr       = 32'h40;
    fetch_addr_en = 1'b1;
    fetch_addr    = 32'h500;
    #1;
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) $display("[TB] FAIL rmid_grant: got %b/%h expected 1/00000040", mem_en, mem_addr); else passed++;
    cyc();
    clear_inputs();
    reset      = 1'b1;
    mem_rvalid = 1'b1;
    #1;
    checks++; if (ls_done !== 1'b0) $display("[TB] FAIL rmid_done_in_reset: got %b expected 0", ls_done); else passed++;
    cyc();
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55555555;
    #1;
    checks++; if (ls_done !== 1'b0 || ls_rdata !== 32'd0) $display("[TB] FAIL rmid_stray: got %b/%h expected 0/00000000", ls_done, ls_rdata); else passed++;
    checks++; if (dut.state !== 2'd0) $display("[TB] FAIL rmid_state: got %0d expected 0", dut.state); else passed++;
    checks++; if (dut.streak_cnt !== 4'd0) $display("[TB] FAIL rmid_streak: got %0d expected 0", dut.streak_cnt); else passed++;
    cyc();
    mem_rvalid = 1'b0;
    ls_en      = 1'b1;
    ls_addr    = 32'h44;
    #1;
    cyc();
    reset = 1'b1;
    #1;
    checks++; if (mem_en !== 1'b0) $display("[TB] FAIL rmid_en_in_reset: got %b expected 0", mem_en); else passed++;
    cyc();
    reset = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h44) $display("[TB] FAIL rmid_first_grant: got %b/%h expected 1/00000044", mem_en, mem_addr); else passed++;
    cyc();
    ls_en      = 1'b0;
    mem_rvalid = 1'b1;
    #1;
    cyc();
    clear_inputs();
  endtask

  task automatic test_stray_idle();
    cyc();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hffffffff;
    #1;
    checks++; if (mem_en !== 1'b0 || fetch_inst_valid !== 1'b0 || ls_done !== 1'b0) $display("[TB] FAIL stray_pulses: got %b/%b/%b expected 0/0/0", mem_en, fetch_inst_valid, ls_done); else passed++;
    checks++; if (fetch_inst !== IDLE_WORD || ls_rdata !== 32'd0) $display("[TB] FAIL stray_data: got %h/%h expected %h/00000000", fetch_inst, ls_rdata, IDLE_WORD); else passed++;
    cyc();
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_fetch_only();
    test_contention();
    test_cancel();
    test_store();
    test_reset_mid_access();
    test_stray_idle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_DATA_STREAK, default 4 (range 1-15): maximum consecutive data grants while fetch is pending.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port fetch_addr  input  32  instruction fetch address.
REQ-005 SHALL have port fetch_addr_en  input  1  fetch request; held high until fetch_inst_valid.
REQ-006 SHALL have port fetch_cancel  input  1  PC override; the outstanding fetch response is discarded.
REQ-007 SHALL have port fetch_inst  output  32  returned instruction word.
REQ-008 SHALL have port fetch_inst_valid  output  1  fetch_inst valid, one-cycle pulse.
REQ-009 SHALL have ports ls_addr/ls_wdata  input  32 each  load/store address and write data.
REQ-010 SHALL have ports ls_en, ls_we  input  1 each  data request (held until ls_done) and write select.
REQ-011 SHALL have port ls_rdata  output  32  load data; ls_done  output  1  data access complete, one-cycle pulse.
REQ-012 SHALL have ports mem_addr/mem_wdata  output  32 each; mem_en/mem_we  output  1 each  shared memory port.
REQ-013 SHALL have ports mem_rdata  input  32; mem_rvalid  input  1  memory response/acknowledge.

Function
REQ-014 SHALL implement states IDLE, FETCH_WAIT and DATA_WAIT, with at most one memory access outstanding.
REQ-015 In IDLE with a winning request, SHALL assert mem_en for exactly that cycle, drive the winner's addr/we/wdata combinationally, latch them, and enter the winner's WAIT state.
REQ-016 In WAIT states, SHALL hold mem_en=0, drive mem_addr/mem_we/mem_wdata from the latched values, and stay until mem_rvalid=1.
REQ-017 Arbitration: if only one requester is active it wins; if both are active, data wins unless streak_cnt == MAX_DATA_STREAK, in which case fetch wins.
REQ-018 streak_cnt (4 bits, saturating): +1 on a data grant while fetch_addr_en=1; cleared on any fetch grant; unchanged otherwise.
REQ-019 A fetch_addr_en that is high and coincident with fetch_cancel in IDLE SHALL NOT be granted that cycle.
REQ-020 FETCH_WAIT with mem_rvalid: SHALL drive fetch_inst=mem_rdata and fetch_inst_valid=1 for one cycle (same cycle, combinational), then return to IDLE.
REQ-021 fetch_cancel asserted during FETCH_WAIT (including the mem_rvalid cycle) SHALL set a drop flag; the response SHALL then be consumed with fetch_inst_valid=0, and the flag cleared on the return to IDLE.
REQ-022 DATA_WAIT with mem_rvalid: SHALL pulse ls_done=1 with ls_rdata=mem_rdata (reads; writes also pulse ls_done), then return to IDLE.
REQ-023 The earliest new grant SHALL be the cycle after a response; back-to-back throughput is one access per two cycles minimum.
REQ-024 mem_rvalid in IDLE SHALL be ignored, with no output pulse.
REQ-025 When not valid, fetch_inst SHALL read 'hc0defec4; ls_rdata SHALL read 0 when ls_done=0.

Reset
REQ-026 During reset: state=IDLE, streak_cnt=0, drop flag=0, latched addr/wdata/we=0, mem_en=0, fetch_inst_valid=0, ls_done=0; mem_rvalid ignored.
REQ-027 Reset asserted mid-access SHALL abandon the access; the next grant is permitted on the first non-reset cycle.

Verification
REQ-028 Fetch-only: fetch_addr=0x100 and en held, mem_rvalid 3 cycles after mem_en with rdata=0x00500093 -> a single mem_en pulse at 0x100; fetch_inst_valid pulse with 0x00500093 in the rvalid cycle.
REQ-029 Contention: fetch and ls_en both held with MAX_DATA_STREAK=4 and 1-cycle memory -> grant order D,D,D,D,F, repeating.
REQ-030 Cancel: fetch_cancel pulses during FETCH_WAIT for addr 0x200 -> the response is consumed with no fetch_inst_valid; the next fetch is issued the cycle after.
REQ-031 Store: ls_en=1, ls_we=1, ls_addr=0x80, ls_wdata=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF on the mem_en cycle; ls_done pulse on mem_rvalid; fetch_inst_valid stays 0.
REQ-032 Reset mid-DATA_WAIT, then a stray mem_rvalid -> no ls_done pulse; state=IDLE; streak_cnt=0.
REQ-033 Stray mem_rvalid in IDLE with no requests -> all outputs remain at reset values.
